// File: rtl/core_step_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_step_scheduler_pkg: shared state encoding and one-hot helper    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_step_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VERLET  = 2'd1,
        ST_RELAX   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // Widest selector bus the helper can produce; callers truncate to WIDTH.
    localparam int c_sel_max_w = 64;

    function automatic logic [c_sel_max_w-1:0] onehot(input logic [31:0] idx);
        return {{(c_sel_max_w-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_step_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_step_scheduler_if: control, mouse and publish bus of the core   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface core_step_scheduler_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic              step_req;
    logic [WIDTH-1:0]  x_mouse;
    logic [WIDTH-1:0]  y_mouse;
    logic              pos_ready;
    logic              clr_overrun;
    logic [WIDTH-1:0]  verlet_cnt_sig;
    logic [WIDTH-1:0]  fix_cnst_sig;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] cnst_addr;
    logic              verlet_we;
    logic              cnst_we;
    logic [WIDTH-1:0]  x_mouse_l;
    logic [WIDTH-1:0]  y_mouse_l;
    logic              busy;
    logic              pos_valid;
    logic              step_done;
    logic              overrun;

    modport master (
        output step_req, x_mouse, y_mouse, pos_ready, clr_overrun,
        input  verlet_cnt_sig, fix_cnst_sig, wr_addr, cnst_addr, verlet_we,
               cnst_we, x_mouse_l, y_mouse_l, busy, pos_valid, step_done, overrun
    );

    modport slave (
        input  step_req, x_mouse, y_mouse, pos_ready, clr_overrun,
        output verlet_cnt_sig, fix_cnst_sig, wr_addr, cnst_addr, verlet_we,
               cnst_we, x_mouse_l, y_mouse_l, busy, pos_valid, step_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/core_step_scheduler_sweep_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_step_scheduler_sweep_counter: node index with terminal flag     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module core_step_scheduler_sweep_counter #(
    parameter int COUNT  = 5,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] idx_next,
    output logic              last
);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(COUNT - 1);

    logic [ADDR_W-1:0] r_idx;

    // The terminal index restarts at zero so successive sweeps chain directly.
    always_comb begin
        idx_next = r_idx;
        if (clear) begin
            idx_next = '0;
        end else if (advance) begin
            idx_next = (r_idx == c_last_idx) ? '0 : r_idx + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else begin
            r_idx <= idx_next;
        end
    end

    assign last = (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/core_step_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_step_scheduler: Verlet sweep, NUM_ITER relax sweeps, publish    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module core_step_scheduler
    import core_step_scheduler_pkg::*;
#(
    parameter int NODE_CONTAINS = 5,
    parameter int NUM_ITER      = 4,
    parameter int WIDTH         = 32,
    parameter int ADDR_W        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    core_step_scheduler_if.slave bus
);
    localparam int c_iter_w = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [c_iter_w-1:0] c_last_iter = c_iter_w'(NUM_ITER - 1);

    state_t              r_state;
    logic [c_iter_w-1:0] r_iter;
    logic                r_verlet_we;
    logic                r_cnst_we;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_cnst_addr;
    logic [WIDTH-1:0]    r_verlet_sel;
    logic [WIDTH-1:0]    r_fix_sel;
    logic [WIDTH-1:0]    r_x_mouse_l;
    logic [WIDTH-1:0]    r_y_mouse_l;
    logic                r_busy;
    logic                r_pos_valid;
    logic                r_step_done;
    logic                r_overrun;

    logic                w_clear;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_idx_next;
    logic                w_last;
    logic [WIDTH-1:0]    w_sel;

    core_step_scheduler_sweep_counter #(
        .COUNT  (NODE_CONTAINS),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .advance  (w_advance),
        .idx_next (w_idx_next),
        .last     (w_last)
    );

    // Counter is cleared on entry to each sweep phase and runs freely through RELAX.
    always_comb begin
        w_clear   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE:   w_clear = bus.step_req;
            ST_VERLET: begin
                w_clear   = w_last;
                w_advance = !w_last;
            end
            ST_RELAX:  w_advance = 1'b1;
            default:   w_advance = 1'b0;
        endcase
    end

    // Outputs are registered from the next index so they line up with the new state.
    assign w_sel = WIDTH'(onehot(32'(w_idx_next)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_iter       <= '0;
            r_verlet_we  <= 1'b0;
            r_cnst_we    <= 1'b0;
            r_wr_addr    <= '0;
            r_cnst_addr  <= '0;
            r_verlet_sel <= '0;
            r_fix_sel    <= '0;
            r_x_mouse_l  <= '0;
            r_y_mouse_l  <= '0;
            r_busy       <= 1'b0;
            r_pos_valid  <= 1'b0;
            r_step_done  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_step_done <= 1'b0;

            if ((r_state != ST_IDLE) && bus.step_req) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.step_req) begin
                        r_state      <= ST_VERLET;
                        r_iter       <= '0;
                        r_busy       <= 1'b1;
                        r_x_mouse_l  <= bus.x_mouse;
                        r_y_mouse_l  <= bus.y_mouse;
                        r_verlet_we  <= 1'b1;
                        r_wr_addr    <= w_idx_next;
                        r_verlet_sel <= w_sel;
                    end
                end
                ST_VERLET: begin
                    if (w_last) begin
                        r_state      <= ST_RELAX;
                        r_iter       <= '0;
                        r_verlet_we  <= 1'b0;
                        r_wr_addr    <= '0;
                        r_verlet_sel <= '0;
                        r_cnst_we    <= 1'b1;
                        r_cnst_addr  <= w_idx_next;
                        r_fix_sel    <= w_sel;
                    end else begin
                        r_wr_addr    <= w_idx_next;
                        r_verlet_sel <= w_sel;
                    end
                end
                ST_RELAX: begin
                    if (w_last && (r_iter == c_last_iter)) begin
                        r_state     <= ST_PUBLISH;
                        r_cnst_we   <= 1'b0;
                        r_cnst_addr <= '0;
                        r_fix_sel   <= '0;
                        r_pos_valid <= 1'b1;
                    end else begin
                        if (w_last) begin
                            r_iter <= r_iter + c_iter_w'(1);
                        end
                        r_cnst_addr <= w_idx_next;
                        r_fix_sel   <= w_sel;
                    end
                end
                ST_PUBLISH: begin
                    if (bus.pos_ready) begin
                        r_state     <= ST_IDLE;
                        r_pos_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_step_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.verlet_we      = r_verlet_we;
    assign bus.cnst_we        = r_cnst_we;
    assign bus.wr_addr        = r_wr_addr;
    assign bus.cnst_addr      = r_cnst_addr;
    assign bus.verlet_cnt_sig = r_verlet_sel;
    assign bus.fix_cnst_sig   = r_fix_sel;
    assign bus.x_mouse_l      = r_x_mouse_l;
    assign bus.y_mouse_l      = r_y_mouse_l;
    assign bus.busy           = r_busy;
    assign bus.pos_valid      = r_pos_valid;
    assign bus.step_done      = r_step_done;
    assign bus.overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_core_step_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_step_scheduler: vector table, corner sequences, random model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_core_step_scheduler;
    localparam int N   = 5;
    localparam int I   = 4;
    localparam int LAT = N * (1 + I) + 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    core_step_scheduler_if #(.WIDTH(32), .ADDR_W(3)) bus ();
    core_step_scheduler_if #(.WIDTH(32), .ADDR_W(1)) bus2 ();

    core_step_scheduler #(.NODE_CONTAINS(N), .NUM_ITER(I), .WIDTH(32), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    core_step_scheduler #(.NODE_CONTAINS(1), .NUM_ITER(1), .WIDTH(32), .ADDR_W(1)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_t is the cycle number within the current step (0 = idle).
    int          m_t;
    logic        m_done;
    logic        m_ovr;
    logic [31:0] m_xl;
    logic [31:0] m_yl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_done = 1'b0; m_ovr = 1'b0; m_xl = '0; m_yl = '0;
    endtask

    task automatic model_step();
        logic set_ovr;
        logic nd;
        if (!reset) begin
            model_reset();
            return;
        end
        set_ovr = bus.step_req && (m_t != 0);
        nd = (m_t == LAT) && bus.pos_ready;
        if (m_t == 0) begin
            if (bus.step_req) begin
                m_t = 1; m_xl = bus.x_mouse; m_yl = bus.y_mouse;
            end
        end else if (m_t < LAT) begin
            m_t++;
        end else if (bus.pos_ready) begin
            m_t = 0;
        end
        m_done = nd;
        if (set_ovr) m_ovr = 1'b1;
        else if (bus.clr_overrun) m_ovr = 1'b0;
    endtask

    task automatic check_all();
        logic vwe, cwe;
        int   wa, ca;
        vwe = (m_t >= 1) && (m_t <= N);
        cwe = (m_t >= N + 1) && (m_t <= N * (1 + I));
        wa  = vwe ? m_t - 1 : 0;
        ca  = cwe ? (m_t - N - 1) % N : 0;
        chk("verlet_we", 64'(bus.verlet_we), 64'(vwe));
        chk("wr_addr", 64'(bus.wr_addr), 64'(wa));
        chk("verlet_cnt_sig", 64'(bus.verlet_cnt_sig), vwe ? (64'd1 << wa) : 64'd0);
        chk("cnst_we", 64'(bus.cnst_we), 64'(cwe));
        chk("cnst_addr", 64'(bus.cnst_addr), 64'(ca));
        chk("fix_cnst_sig", 64'(bus.fix_cnst_sig), cwe ? (64'd1 << ca) : 64'd0);
        chk("pos_valid", 64'(bus.pos_valid), 64'(m_t == LAT));
        chk("busy", 64'(bus.busy), 64'(m_t != 0));
        chk("step_done", 64'(bus.step_done), 64'(m_done));
        chk("overrun", 64'(bus.overrun), 64'(m_ovr));
        chk("x_mouse_l", 64'(bus.x_mouse_l), 64'(m_xl));
        chk("y_mouse_l", 64'(bus.y_mouse_l), 64'(m_yl));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_verlet_we"}, 64'(bus.verlet_we), 64'd0);
        chk({tag, "_cnst_we"}, 64'(bus.cnst_we), 64'd0);
        chk({tag, "_sels"}, 64'(bus.verlet_cnt_sig | bus.fix_cnst_sig), 64'd0);
        chk({tag, "_addrs"}, 64'(bus.wr_addr | bus.cnst_addr), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_pos_valid"}, 64'(bus.pos_valid), 64'd0);
        chk({tag, "_step_done"}, 64'(bus.step_done), 64'd0);
        chk({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
        chk({tag, "_mouse_l"}, 64'(bus.x_mouse_l | bus.y_mouse_l), 64'd0);
    endtask

    typedef struct {
        int         cyc;
        logic       vwe;
        logic [2:0] waddr;
        logic       cwe;
        logic [2:0] caddr;
        logic       pv;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int k;
        int done_cnt;
        logic [31:0] vsel, csel;

        checks = 0; failures = 0;
        tbl[0]  = '{1,  1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3,  1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{5,  1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{6,  1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{10, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{11, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{18, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{25, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{26, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{27, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{28, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        bus.step_req = 1'b0; bus.x_mouse = 32'd0; bus.y_mouse = 32'd0;
        bus.pos_ready = 1'b0; bus.clr_overrun = 1'b0;
        bus2.step_req = 1'b0; bus2.x_mouse = 32'd0; bus2.y_mouse = 32'd0;
        bus2.pos_ready = 1'b0; bus2.clr_overrun = 1'b0;
        model_reset();
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Nominal step against the hand-written vector table.
        bus.x_mouse = 32'd11; bus.y_mouse = 32'd22;
        bus.step_req = 1'b1; bus.pos_ready = 1'b1;
        tick();
        bus.step_req = 1'b0;
        k = 0;
        for (int c = 1; c <= 28; c++) begin
            if (k < 11 && tbl[k].cyc == c) begin
                vsel = tbl[k].vwe ? (32'd1 << tbl[k].waddr) : 32'd0;
                csel = tbl[k].cwe ? (32'd1 << tbl[k].caddr) : 32'd0;
                chk("tbl_verlet_we", 64'(bus.verlet_we), 64'(tbl[k].vwe));
                chk("tbl_wr_addr", 64'(bus.wr_addr), 64'(tbl[k].waddr));
                chk("tbl_verlet_sel", 64'(bus.verlet_cnt_sig), 64'(vsel));
                chk("tbl_cnst_we", 64'(bus.cnst_we), 64'(tbl[k].cwe));
                chk("tbl_cnst_addr", 64'(bus.cnst_addr), 64'(tbl[k].caddr));
                chk("tbl_fix_sel", 64'(bus.fix_cnst_sig), 64'(csel));
                chk("tbl_pos_valid", 64'(bus.pos_valid), 64'(tbl[k].pv));
                chk("tbl_step_done", 64'(bus.step_done), 64'(tbl[k].done));
                chk("tbl_busy", 64'(bus.busy), 64'(tbl[k].busy));
                chk("tbl_x_mouse_l", 64'(bus.x_mouse_l), 64'd11);
                k++;
            end
            tick();
        end

        // Renderer stalls for 10 cycles in PUBLISH.
        bus.pos_ready = 1'b0; bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int c = 1; c < LAT; c++) tick();
        chk("hold_pos_valid_at_26", 64'(bus.pos_valid), 64'd1);
        for (int c = 0; c < 10; c++) tick();
        chk("hold_pos_valid_after_stall", 64'(bus.pos_valid), 64'd1);
        bus.pos_ready = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            done_cnt += int'(bus.step_done);
        end
        chk("hold_done_count", 64'(done_cnt), 64'd1);

        // Overrun: request at cycle 3, then clear+request together while busy.
        bus.pos_ready = 1'b0; bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        tick(); tick();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        chk("overrun_set", 64'(bus.overrun), 64'd1);
        for (int c = 4; c < LAT; c++) tick();
        chk("overrun_len_pos_valid", 64'(bus.pos_valid), 64'd1);
        bus.clr_overrun = 1'b1; bus.step_req = 1'b1;
        tick();
        chk("overrun_set_wins", 64'(bus.overrun), 64'd1);
        bus.clr_overrun = 1'b0; bus.step_req = 1'b0; bus.pos_ready = 1'b1;
        tick();
        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("overrun_cleared", 64'(bus.overrun), 64'd0);

        // Mouse latch holds across a mid-step change.
        bus.x_mouse = 32'd100; bus.y_mouse = 32'd5; bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        bus.x_mouse = 32'd200;
        tick();
        chk("mouse_hold", 64'(bus.x_mouse_l), 64'd100);
        for (int c = 0; c < 21; c++) tick();
        chk("mouse_step_idle", 64'(bus.busy), 64'd0);
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        chk("mouse_new_step", 64'(bus.x_mouse_l), 64'd200);
        for (int c = 0; c < 28; c++) tick();

        // Asynchronous reset during RELAX iteration 2.
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        tick(); tick();
        #2;
        reset = 1'b1;
        tick();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int c = 1; c < LAT - 1; c++) tick();
        chk("post_reset_pv_25", 64'(bus.pos_valid), 64'd0);
        tick();
        chk("post_reset_pv_26", 64'(bus.pos_valid), 64'd1);
        tick(); tick();

        // Minimal configuration: one node, one relax sweep.
        bus2.step_req = 1'b1; bus2.pos_ready = 1'b1;
        tick();
        bus2.step_req = 1'b0;
        chk("small_verlet_we", 64'(bus2.verlet_we), 64'd1);
        chk("small_verlet_sel", 64'(bus2.verlet_cnt_sig), 64'd1);
        tick();
        chk("small_cnst_we", 64'(bus2.cnst_we), 64'd1);
        chk("small_verlet_off", 64'(bus2.verlet_we), 64'd0);
        chk("small_fix_sel", 64'(bus2.fix_cnst_sig), 64'd1);
        tick();
        chk("small_pos_valid", 64'(bus2.pos_valid), 64'd1);
        chk("small_cnst_off", 64'(bus2.cnst_we), 64'd0);
        tick();
        chk("small_step_done", 64'(bus2.step_done), 64'd1);
        chk("small_idle", 64'(bus2.busy), 64'd0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bus.step_req    = ($urandom_range(0, 7) == 0);
            bus.pos_ready   = ($urandom_range(0, 2) != 0);
            bus.clr_overrun = ($urandom_range(0, 15) == 0);
            bus.x_mouse     = $urandom;
            bus.y_mouse     = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
